// File: rtl/mario_state_ctrl_pkg.sv
// Shared definitions for the mario state record controller: record layout,
// power-on values of the sprite snapshot, and the FSM state encoding.
package mario_state_ctrl_pkg;

    // Word offsets of the state record fields from the record base address
    localparam int MARIO_X_OFS   = 0;
    localparam int MARIO_Y_OFS   = 1;
    localparam int MARIO_POS_OFS = 2;

    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h1000;

    // Snapshot values shown by the renderer before the first update
    localparam int RESET_X   = 100;
    localparam int RESET_Y   = 350;
    localparam int RESET_POS = 0;

    localparam int POS_WIDTH = 5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_X = 3'd1,
        RD_Y = 3'd2,
        RD_P = 3'd3,
        CALC = 3'd4,
        WR_X = 3'd5,
        WR_Y = 3'd6,
        WR_P = 3'd7
    } state_t;

    // Movement animation advances while moving and wraps after the last frame;
    // standing still snaps back to the first position.
    function automatic logic [POS_WIDTH-1:0] advance_pos(
        input logic [POS_WIDTH-1:0] pos,
        input logic                 moved,
        input logic [POS_WIDTH-1:0] last
    );
        if (!moved)
            return '0;
        return (pos == last) ? '0 : pos + 1'b1;
    endfunction

endpackage

// File: rtl/mario_state_ctrl_axis_step.sv
// Clamp-then-step for one screen axis. The input is forced into [MIN,MAX]
// first so a corrupt stored coordinate can never escape the playfield.
module axis_step #(
    parameter int WIDTH = 16,
    parameter int MIN   = 0,
    parameter int MAX   = 608,
    parameter int STEP  = 2
) (
    input  logic [WIDTH-1:0] v,
    input  logic             dec,
    input  logic             inc,
    output logic [WIDTH-1:0] v_next,
    output logic             changed
);

    localparam logic [WIDTH-1:0] LO    = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] HI    = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] LO_TH = WIDTH'(MIN + STEP);
    localparam logic [WIDTH-1:0] HI_TH = WIDTH'(MAX - STEP);
    localparam logic [WIDTH-1:0] ST    = WIDTH'(STEP);

    logic [WIDTH-1:0] v_c;

    // Clamp, then move one step unless both or neither direction is pressed
    always_comb begin
        // "<= LO" / ">= HI" keep the compare meaningful when MIN is zero
        if (v <= LO)
            v_c = LO;
        else if (v >= HI)
            v_c = HI;
        else
            v_c = v;

        v_next = v_c;
        if (dec && !inc)
            v_next = (v_c < LO_TH) ? LO : v_c - ST;
        else if (inc && !dec)
            v_next = (v_c > HI_TH) ? HI : v_c + ST;

        changed = (v_next != v);
    end

endmodule

// File: rtl/mario_state_ctrl.sv
// Per-frame read-modify-write of the mario state record over one bram port,
// with a registered snapshot published to the sprite renderer.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for frame_tick; snapshot stable
// RD_X  | address x word
// RD_Y  | address y word, capture x
// RD_P  | address pos word, capture y
// CALC  | capture pos, compute new record, launch x write
// WR_X  | x being written, launch y write
// WR_Y  | y being written, launch pos write
// WR_P  | pos being written, publish snapshot (done next cycle)
module mario_state_ctrl
    import mario_state_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DEFAULT_BASE_ADDR),
    parameter int                    STEP       = 2,
    parameter int                    X_MIN      = 0,
    parameter int                    X_MAX      = 608,
    parameter int                    Y_MIN      = 0,
    parameter int                    Y_MAX      = 448,
    parameter int                    NUM_POS    = 21
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_tick,
    input  logic                  btn_left,
    input  logic                  btn_right,
    input  logic                  btn_up,
    input  logic                  btn_down,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] mario_x,
    output logic [DATA_WIDTH-1:0] mario_y,
    output logic [POS_WIDTH-1:0]  mario_pos,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_X = BASE_ADDR + ADDR_WIDTH'(MARIO_X_OFS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_Y = BASE_ADDR + ADDR_WIDTH'(MARIO_Y_OFS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_P = BASE_ADDR + ADDR_WIDTH'(MARIO_POS_OFS);
    localparam logic [POS_WIDTH-1:0]  POS_LAST = POS_WIDTH'(NUM_POS - 1);

    state_t                  state, state_n;
    logic [3:0]              btn_q, btn_n;        // {left, right, up, down}
    logic [DATA_WIDTH-1:0]   x_q, x_n, y_q, y_n;  // read values, then new values after CALC
    logic [POS_WIDTH-1:0]    pos_q, pos_n;
    logic [ADDR_WIDTH-1:0]   addr_n;
    logic [DATA_WIDTH-1:0]   wdata_n;
    logic                    we_n, done_n, overrun_n;
    logic [DATA_WIDTH-1:0]   pub_x_n, pub_y_n;
    logic [POS_WIDTH-1:0]    pub_pos_n;

    logic [DATA_WIDTH-1:0]   x_step, y_step;
    logic                    x_changed, y_changed;
    logic [POS_WIDTH-1:0]    pos_rd, pos_calc;

    axis_step #(.WIDTH(DATA_WIDTH), .MIN(X_MIN), .MAX(X_MAX), .STEP(STEP)) u_axis_x (
        .v       (x_q),
        .dec     (btn_q[3]),
        .inc     (btn_q[2]),
        .v_next  (x_step),
        .changed (x_changed)
    );

    axis_step #(.WIDTH(DATA_WIDTH), .MIN(Y_MIN), .MAX(Y_MAX), .STEP(STEP)) u_axis_y (
        .v       (y_q),
        .dec     (btn_q[1]),
        .inc     (btn_q[0]),
        .v_next  (y_step),
        .changed (y_changed)
    );

    // Out-of-range stored position restarts the animation from zero
    always_comb begin
        pos_rd   = (mem_rdata >= DATA_WIDTH'(NUM_POS)) ? '0 : mem_rdata[POS_WIDTH-1:0];
        pos_calc = advance_pos(pos_rd, x_changed | y_changed, POS_LAST);
    end

    // Next state plus next values of every registered output
    always_comb begin
        state_n   = state;
        btn_n     = btn_q;
        x_n       = x_q;
        y_n       = y_q;
        pos_n     = pos_q;
        addr_n    = mem_addr;
        wdata_n   = mem_wdata;
        we_n      = 1'b0;
        done_n    = 1'b0;
        pub_x_n   = mario_x;
        pub_y_n   = mario_y;
        pub_pos_n = mario_pos;
        overrun_n = overrun | (frame_tick && (state != IDLE));

        case (state)
            IDLE: begin
                if (frame_tick) begin
                    state_n = RD_X;
                    btn_n   = {btn_left, btn_right, btn_up, btn_down};
                    addr_n  = ADDR_X;
                end
            end
            RD_X: begin
                state_n = RD_Y;
                addr_n  = ADDR_Y;
            end
            RD_Y: begin
                state_n = RD_P;
                addr_n  = ADDR_P;
                x_n     = mem_rdata;
            end
            RD_P: begin
                state_n = CALC;
                y_n     = mem_rdata;
            end
            CALC: begin
                state_n = WR_X;
                x_n     = x_step;
                y_n     = y_step;
                pos_n   = pos_calc;
                addr_n  = ADDR_X;
                wdata_n = x_step;
                we_n    = 1'b1;
            end
            WR_X: begin
                state_n = WR_Y;
                addr_n  = ADDR_Y;
                wdata_n = y_q;
                we_n    = 1'b1;
            end
            WR_Y: begin
                state_n = WR_P;
                addr_n  = ADDR_P;
                wdata_n = {{(DATA_WIDTH-POS_WIDTH){1'b0}}, pos_q};
                we_n    = 1'b1;
            end
            WR_P: begin
                state_n   = IDLE;
                done_n    = 1'b1;
                pub_x_n   = x_q;
                pub_y_n   = y_q;
                pub_pos_n = pos_q;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset abandons any update in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            btn_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            pos_q     <= '0;
            mem_addr  <= ADDR_X;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            mario_x   <= DATA_WIDTH'(RESET_X);
            mario_y   <= DATA_WIDTH'(RESET_Y);
            mario_pos <= POS_WIDTH'(RESET_POS);
        end else begin
            state     <= state_n;
            btn_q     <= btn_n;
            x_q       <= x_n;
            y_q       <= y_n;
            pos_q     <= pos_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            mem_we    <= we_n;
            done      <= done_n;
            overrun   <= overrun_n;
            mario_x   <= pub_x_n;
            mario_y   <= pub_y_n;
            mario_pos <= pub_pos_n;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mario_state_ctrl.sv
// Bench for mario_state_ctrl: bram model, directed updates, and a done-driven
// scoreboard that checks the snapshot and the written record.
module tb_mario_state_ctrl;

    logic        clk = 1'b0;
    logic        reset, frame_tick;
    logic        btn_left, btn_right, btn_up, btn_down;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [15:0] mario_x, mario_y;
    logic [4:0]  mario_pos;
    logic        busy, done, overrun;

    logic [15:0] mem [0:7];
    logic        pl_we = 1'b0;
    logic [2:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [4:0]  pos;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    mario_state_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .mario_x(mario_x), .mario_y(mario_y), .mario_pos(mario_pos),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Bram model: 1-cycle read latency, bench preload port has priority
    always @(posedge clk) begin
        if (pl_we)
            mem[pl_addr] <= pl_data;
        else if (mem_we)
            mem[mem_addr[2:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[2:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int x, input int y, input int p);
        exp_t e;
        e.x   = 16'(x);
        e.y   = 16'(y);
        e.pos = 5'(p);
        return e;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int x, input int y, input int p);
        for (int i = 0; i < 3; i++) begin
            pl_we   = 1'b1;
            pl_addr = 3'(i);
            pl_data = (i == 0) ? 16'(x) : (i == 1) ? 16'(y) : 16'(p);
            cyc();
        end
        pl_we = 1'b0;
    endtask

    // Drive a tick with buttons; returns during cycle T+1
    task automatic start(input bit l, input bit r, input bit u, input bit d,
                         input bit expect_done, input exp_t e);
        btn_left = l; btn_right = r; btn_up = u; btn_down = d;
        frame_tick = 1'b1;
        if (expect_done)
            exp_q.push_back(e);
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 20) begin
            cyc();
            n++;
        end
        check({name, "_done_seen"}, 32'(done), 32'd1);
        cyc();
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expected record
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending update");
            end else begin
                mon_e = exp_q.pop_front();
                check("snap_x", 32'(mario_x), 32'(mon_e.x));
                check("snap_y", 32'(mario_y), 32'(mon_e.y));
                check("snap_pos", 32'(mario_pos), 32'(mon_e.pos));
                check("mem_x", 32'(mem[0]), 32'(mon_e.x));
                check("mem_y", 32'(mem[1]), 32'(mon_e.y));
                check("mem_pos", 32'(mem[2]), 32'(mon_e.pos));
            end
        end
        if (!reset && mem_we)
            check("we_addr_range", {19'd0, mem_addr[15:3]}, 32'h200);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; frame_tick = 1'b0;
        btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0;
        cyc();
        check("rst_we", 32'(mem_we), 0);
        check("rst_addr", 32'(mem_addr), 32'h1000);
        check("rst_wdata", 32'(mem_wdata), 0);
        check("rst_x", 32'(mario_x), 100);
        check("rst_y", 32'(mario_y), 350);
        check("rst_pos", 32'(mario_pos), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_overrun", 32'(overrun), 0);
        cyc();
        reset = 1'b0;

        // 1: idle update, full cycle-by-cycle bus timing
        preload(100, 350, 0);
        start(0, 0, 0, 0, 1, mk(100, 350, 0));
        check("t1_addr1", 32'(mem_addr), 32'h1000); check("t1_we1", 32'(mem_we), 0);
        check("t1_busy1", 32'(busy), 1);
        cyc(); check("t1_addr2", 32'(mem_addr), 32'h1001); check("t1_we2", 32'(mem_we), 0);
        cyc(); check("t1_addr3", 32'(mem_addr), 32'h1002); check("t1_we3", 32'(mem_we), 0);
        cyc(); check("t1_we4", 32'(mem_we), 0);
        cyc(); check("t1_addr5", 32'(mem_addr), 32'h1000); check("t1_we5", 32'(mem_we), 1);
        check("t1_wd5", 32'(mem_wdata), 100);
        cyc(); check("t1_addr6", 32'(mem_addr), 32'h1001); check("t1_we6", 32'(mem_we), 1);
        check("t1_wd6", 32'(mem_wdata), 350);
        cyc(); check("t1_addr7", 32'(mem_addr), 32'h1002); check("t1_we7", 32'(mem_we), 1);
        check("t1_wd7", 32'(mem_wdata), 0); check("t1_busy7", 32'(busy), 1);
        cyc(); check("t1_done8", 32'(done), 1); check("t1_we8", 32'(mem_we), 0);
        check("t1_busy8", 32'(busy), 0); check("t1_overrun", 32'(overrun), 0);
        cyc(); check("t1_done_pulse", 32'(done), 0);

        // 2: btn_right for 21 frames, position wraps 20 -> 0
        preload(100, 350, 0);
        for (int k = 1; k <= 21; k++) begin
            start(0, 1, 0, 0, 1, mk(100 + 2 * k, 350, k % 21));
            wait_done("t2");
        end
        check("t2_final_pos_mem", 32'(mem[2]), 0);

        // 3: clamp boundaries and corrupt values
        preload(1, 350, 0);    start(1, 0, 0, 0, 1, mk(0, 350, 1));   wait_done("t3_left_min");
        preload(607, 350, 0);  start(0, 1, 0, 0, 1, mk(608, 350, 1)); wait_done("t3_right_max");
        preload(9000, 350, 0); start(0, 1, 0, 0, 1, mk(608, 350, 1)); wait_done("t3_corrupt_x");
        preload(608, 350, 4);  start(0, 1, 0, 0, 1, mk(608, 350, 0)); wait_done("t3_pinned");
        preload(300, 447, 0);  start(0, 0, 0, 1, 1, mk(300, 448, 1)); wait_done("t3_down_max");
        preload(300, 350, 30); start(0, 0, 0, 1, 1, mk(300, 352, 1)); wait_done("t3_bad_pos");

        // 4: opposing x buttons cancel; late button changes ignored
        preload(200, 350, 0);
        start(1, 1, 0, 1, 1, mk(200, 352, 1));
        cyc();
        btn_left = 0; btn_right = 0; btn_up = 1; btn_down = 0;
        wait_done("t4");
        btn_up = 0;

        // 5: tick while busy sets overrun; tick on the done cycle is accepted
        preload(100, 350, 0);
        start(0, 0, 0, 0, 1, mk(100, 350, 0));
        cyc(); cyc();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        check("t5_overrun", 32'(overrun), 1);
        check("t5_still_busy", 32'(busy), 1);
        check("t5_we4", 32'(mem_we), 0);
        cyc(); cyc(); cyc(); cyc();
        check("t5_done8", 32'(done), 1);
        start(0, 0, 0, 0, 1, mk(100, 350, 0));
        check("t5_busy9", 32'(busy), 1);
        check("t5_addr9", 32'(mem_addr), 32'h1000);
        wait_done("t5_second");
        check("t5_overrun_sticky", 32'(overrun), 1);

        // 6: reset during WR_Y aborts the update
        preload(100, 350, 5);
        start(0, 1, 0, 0, 0, mk(0, 0, 0));
        cyc(); cyc(); cyc(); cyc(); cyc();
        check("t6_we6", 32'(mem_we), 1);
        check("t6_addr6", 32'(mem_addr), 32'h1001);
        reset = 1'b1;
        btn_right = 0;
        cyc();
        reset = 1'b0;
        check("t6_we_after", 32'(mem_we), 0);
        check("t6_busy_after", 32'(busy), 0);
        check("t6_overrun_clr", 32'(overrun), 0);
        check("t6_x_rst", 32'(mario_x), 100);
        check("t6_y_rst", 32'(mario_y), 350);
        check("t6_pos_rst", 32'(mario_pos), 0);
        check("t6_addr_rst", 32'(mem_addr), 32'h1000);
        check("t6_wdata_rst", 32'(mem_wdata), 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t6_no_resume_we", 32'(mem_we), 0);
        end
        check("t6_mem_x", 32'(mem[0]), 102);
        check("t6_mem_pos_kept", 32'(mem[2]), 5);
        start(0, 1, 0, 0, 1, mk(104, 350, 6));
        wait_done("t6_after_reset");
        btn_right = 0;

        cyc(); cyc();
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
